// File: rtl/decoder_nx.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and optional auto-scan.
// Define DECODER_NX_SCAN_EN to build the scan state, dwell counter and wrap pulse.
//
// state  | meaning
// IDLE   | disabled or just out of reset, z cleared
// DIRECT | z follows the last accepted select value
// SCAN   | z walks bit 0..2^N-1, each held dwell+1 cycles
module decoder_nx #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       i,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    z,
    output logic               z_valid,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [2**N-1:0] z_nxt;
    logic            z_valid_nxt;
    logic            accept;

`ifdef DECODER_NX_SCAN_EN
    logic [N-1:0]       idx, idx_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               wrap_nxt;

    assign i_ready = en && (state != SCAN) && !mode;
`else
    logic unused_cfg;

    assign unused_cfg = ^{mode, dwell};
    assign i_ready    = en;
    assign wrap       = 1'b0;
`endif

    assign accept = i_valid && i_ready;

    always_comb begin
        state_nxt   = state;
        z_nxt       = z;
        z_valid_nxt = z_valid;
`ifdef DECODER_NX_SCAN_EN
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        wrap_nxt    = 1'b0;
`endif
        if (!en) begin
            state_nxt   = IDLE;
            z_nxt       = '0;
            z_valid_nxt = 1'b0;
`ifdef DECODER_NX_SCAN_EN
            idx_nxt     = '0;
            cnt_nxt     = '0;
        end else if (mode && state != SCAN) begin
            state_nxt   = SCAN;
            idx_nxt     = '0;
            cnt_nxt     = '0;
            z_nxt       = '0;
            z_nxt[0]    = 1'b1;
            z_valid_nxt = 1'b1;
        end else if (mode) begin
            // dwell is compared live; equality (not >=) lets cnt roll over if dwell drops below it
            if (cnt == dwell) begin
                cnt_nxt        = '0;
                idx_nxt        = idx + 1'b1;
                z_nxt          = '0;
                z_nxt[idx_nxt] = 1'b1;
                wrap_nxt       = &idx;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
`endif
        end else begin
            // leaving SCAN holds z; i_ready was low this cycle so nothing loads
            state_nxt = DIRECT;
            if (accept) begin
                z_nxt       = '0;
                z_nxt[i]    = 1'b1;
                z_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            z       <= '0;
            z_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            z       <= z_nxt;
            z_valid <= z_valid_nxt;
        end
    end

`ifdef DECODER_NX_SCAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_nx.sv
// Self-checking bench for decoder_nx: an N=2 and an N=3 instance against a cycle model.
// Scan checks are only built when DECODER_NX_SCAN_EN is defined.
module tb_decoder_nx;

    localparam int DW = 8;
`ifdef DECODER_NX_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          mode    = 1'b0;
    logic          i_valid = 1'b0;
    logic [1:0]    i0      = '0;
    logic [2:0]    i1      = '0;
    logic [DW-1:0] dwell0  = '0;
    logic [DW-1:0] dwell1  = '0;
    logic          rdy0, rdy1, zv0, zv1, wrap0, wrap1;
    logic [3:0]    z0;
    logic [7:0]    z1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_z    [2];
    bit         m_zv   [2];
    bit         m_wrap [2];
    bit         m_scan [2];
    int         m_t    [2];

    always #5 clk = ~clk;

    decoder_nx #(.N(2), .DWELL_W(DW)) u_n2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i0), .i_valid(i_valid),
        .i_ready(rdy0), .dwell(dwell0), .z(z0), .z_valid(zv0), .wrap(wrap0)
    );

    decoder_nx #(.N(3), .DWELL_W(DW)) u_n3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i1), .i_valid(i_valid),
        .i_ready(rdy1), .dwell(dwell1), .z(z1), .z_valid(zv1), .wrap(wrap1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_z[k]    = '0;
            m_zv[k]   = 1'b0;
            m_wrap[k] = 1'b0;
            m_scan[k] = 1'b0;
            m_t[k]    = 0;
        end
    endtask

    // Scan position is derived from cycles since entry: t/(dwell+1) mod 2^n.
    task automatic model_step(input int k, input int n, input int sel, input int dw);
        bit md, rdy;
        md        = SCAN && mode;
        rdy       = en && !md && !m_scan[k];
        m_wrap[k] = 1'b0;
        if (!en) begin
            m_scan[k] = 1'b0;
            m_z[k]    = '0;
            m_zv[k]   = 1'b0;
        end else if (md) begin
            if (m_scan[k]) m_t[k]++;
            else begin
                m_scan[k] = 1'b1;
                m_t[k]    = 0;
            end
            m_z[k]    = 8'(1 << ((m_t[k] / (dw + 1)) % (1 << n)));
            m_zv[k]   = 1'b1;
            m_wrap[k] = (m_t[k] != 0) && (m_t[k] % ((1 << n) * (dw + 1)) == 0);
        end else begin
            m_scan[k] = 1'b0;
            if (i_valid && rdy) begin
                m_z[k]  = 8'(1 << sel);
                m_zv[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            model_step(0, 2, int'(i0), int'(dwell0));
            model_step(1, 3, int'(i1), int'(dwell1));
        end
    end

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (rst_n) begin
            chk("z_n2",     32'(z0),    32'(m_z[0]));
            chk("zv_n2",    32'(zv0),   32'(m_zv[0]));
            chk("wrap_n2",  32'(wrap0), 32'(m_wrap[0]));
            chk("ready_n2", 32'(rdy0),  32'(en && !(SCAN && mode) && !m_scan[0]));
            chk("z_n3",     32'(z1),    32'(m_z[1]));
            chk("zv_n3",    32'(zv1),   32'(m_zv[1]));
            chk("wrap_n3",  32'(wrap1), 32'(m_wrap[1]));
            chk("ready_n3", 32'(rdy1),  32'(en && !(SCAN && mode) && !m_scan[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int guard, wraps0, wraps1;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_z",  32'(z0),  32'h0);
        chk("rst_zv", 32'(zv0), 32'h0);
        rst_n = 1'b1;

        en = 1'b1; mode = 1'b0; i0 = 2'd3; i1 = 3'd6; i_valid = 1'b1;
        tick();
        chk("dir_i3",    32'(z0),  32'h8);
        chk("dir_i3_zv", 32'(zv0), 32'h1);
        chk("dir_n3_i6", 32'(z1),  32'h40);
        i_valid = 1'b0; i0 = 2'd0; i1 = 3'd1;
        tick();
        chk("dir_hold", 32'(z0), 32'h8);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i0 = 2'(k);
            i1 = 3'(7 - k);
            tick();
            chk("dir_b2b", 32'(z0), 32'(1 << k));
        end
        chk("dir_n3_i5", 32'(z1), 32'h20);

        en = 1'b0; i0 = 2'd1;
        #1 chk("ready_en0", 32'(rdy0), 32'h0);
        tick();
        chk("en0_z",  32'(z0),  32'h0);
        chk("en0_zv", 32'(zv0), 32'h0);
        en = 1'b1; i0 = 2'd2; i1 = 3'd3;
        tick();
        chk("idle_accept", 32'(z0), 32'h4);
        i_valid = 1'b0;

        #4 rst_n = 1'b0;
        #1;
        chk("async_rst_z",    32'(z0),    32'h0);
        chk("async_rst_zv",   32'(zv0),   32'h0);
        chk("async_rst_wrap", 32'(wrap0), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_zv", 32'(zv0), 32'h0);

`ifdef DECODER_NX_SCAN_EN
        dwell0 = 8'd2; dwell1 = 8'd0; mode = 1'b1;
        tick();
        chk("scan_entry",      32'(z0),    32'h1);
        chk("scan_entry_wrap", 32'(wrap0), 32'h0);
        chk("scan_ready",      32'(rdy0),  32'h0);
        wraps0 = 0;
        wraps1 = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (wrap0) wraps0++;
            if (wrap1) wraps1++;
            if (c == 3)  chk("scan_pos1",  32'(z0),    32'h2);
            if (c == 12) chk("scan_wrap12", 32'(wrap0), 32'h1);
        end
        chk("wraps_n2", 32'(wraps0), 32'd1);
        chk("wraps_n3", 32'(wraps1), 32'd2);
        guard = 0;
        while (z0 !== 4'b0100 && guard < 10) begin
            tick();
            guard++;
        end
        chk("scan_reach_0100", 32'(z0), 32'h4);
        en = 1'b0;
        tick();
        chk("scan_en0_z",  32'(z0),  32'h0);
        chk("scan_en0_zv", 32'(zv0), 32'h0);
        en = 1'b1;
        tick();
        chk("rescan_z",    32'(z0),    32'h1);
        chk("rescan_wrap", 32'(wrap0), 32'h0);
        repeat (3) tick();
        mode = 1'b0; i_valid = 1'b1; i0 = 2'd3; i1 = 3'd2;
        #1 chk("scan_exit_ready", 32'(rdy0), 32'h0);
        tick();
        chk("scan_exit_hold", 32'(z0), 32'h2);
        tick();
        chk("scan_exit_load", 32'(z0), 32'h8);
        i_valid = 1'b0;
`else
        mode = 1'b1; dwell0 = 8'd5; dwell1 = 8'd5; i0 = 2'd1; i1 = 3'd4; i_valid = 1'b1;
        #1 chk("noscan_ready", 32'(rdy0), 32'h1);
        tick();
        chk("noscan_z",    32'(z0),    32'h2);
        chk("noscan_wrap", 32'(wrap0), 32'h0);
        i_valid = 1'b0;
        repeat (3) tick();
        chk("noscan_hold", 32'(z0),    32'h2);
        chk("noscan_wrap2", 32'(wrap0), 32'h0);
`endif
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_nx.md
# decoder_nx

Parametrised, registered N-to-2^N one-hot decoder. It has a valid/ready input handshake and an optional auto-scan mode that walks a single active output across all 2^N lines with a programmable dwell time. It sits between control logic and multiplexed loads such as display digits, row selects and chip selects. Two ways to drive it:
- **Direct:** it replaces a combinational 2-to-4 style decoder where a registered, glitch-free output is required.
- **Scan:** it generates the select sequence itself.

## Interface
Parameters:
- N, 2, select width; output width is 2^N (N ≥ 1)
- DWELL_W, 8, width of dwell count input

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; 0 forces outputs idle
- mode  input  1  0 = direct decode, 1 = scan
- i  input  N  select value (direct mode)
- i_valid  input  1  i is valid
- i_ready  output  1  input accepted this cycle when i_valid && i_ready
- dwell  input  DWELL_W  extra cycles each scan position is held
- z  output  2^N  registered one-hot (or all-zero) output
- z_valid  output  1  z holds a decoded/scan value
- wrap  output  1  one-cycle pulse when scan returns to position 0

## Operation
- States: IDLE, DIRECT, SCAN.
- Reset (async, rst_n=0) sets the following immediately:
  - z=0, z_valid=0, wrap=0
  - state IDLE, position index idx=0, dwell counter cnt=0
- Any state with en=0 → IDLE on next edge. z=0, z_valid=0, wrap=0, idx=0, cnt=0.
- IDLE with en=1 → DIRECT if mode=0, SCAN if mode=1.
- i_ready = en && (state≠SCAN) && !mode. It is combinational and never depends on i_valid.
- DIRECT behaviour:
  - On accept, the next edge loads z = 1 << i and sets z_valid=1.
  - With no accept, z and z_valid hold.
  - An accept in the same cycle as the IDLE→DIRECT transition is honoured.
- SCAN entry (from IDLE or DIRECT) sets idx=0, cnt=0, z=1<<0, z_valid=1. wrap does not pulse on entry.
- SCAN per cycle:
  - If cnt==dwell: cnt←0, idx←idx+1 (mod 2^N), z←1<<(idx+1).
  - Otherwise: cnt←cnt+1.
  - dwell is compared live; lowering it below cnt advances on the next cnt wrap at 2^DWELL_W.
- Each position is therefore active dwell+1 cycles. A full sweep takes 2^N·(dwell+1) cycles.
- wrap: asserted for exactly the cycle in which z first shows bit 0 after idx wraps from 2^N−1.
- SCAN→DIRECT (mode falls, en=1): z and z_valid hold the last scan value until the next accepted input. i_valid is ignored while in SCAN.
- z is always one-hot when z_valid=1, and all-zero when z_valid=0.

## Timing
- Direct latency is 1 cycle: the input accepted at edge k appears on z after edge k.
- Back-to-back accepts every cycle are supported; throughput is 1 per cycle.
- Scan entry appears on z 1 cycle after the mode/en condition is sampled.
- All outputs except i_ready are registered; there are no combinational paths from inputs to z, z_valid or wrap.
- A reset deasserted mid-operation resumes from IDLE. A reset asserted mid-scan clears z within the same cycle (async).

## Configuration
- DECODER_NX_SCAN_EN defined: SCAN state, dwell counter and wrap are present, as described above.
- DECODER_NX_SCAN_EN undefined:
  - mode and dwell are ignored (treated as 0).
  - The SCAN state and counter are not built, and wrap is tied to 0.
  - i_ready = en.
  - The block is a pure registered direct decoder.

## Test plan
- Reset: assert rst_n=0 mid-operation with z=4'b0100 → z=0, z_valid=0, wrap=0 immediately, before the next clk edge.
- Direct, N=2: en=1, mode=0, i=2'b11 with i_valid=1 for one cycle → z=4'b1000 and z_valid=1 the next cycle, held after i_valid drops. Then i=0,1,2 on consecutive cycles → z=0001, 0010, 0100 on consecutive cycles.
- Scan, N=2, dwell=2: mode=1 → z=0001 for 3 cycles, then 0010, 0100, 1000 for 3 cycles each, then 0001 again. wrap pulses exactly once, 12 cycles after entry, and i_ready=0 throughout.
- Scan, dwell=0, N=3: z advances one position per cycle, and wrap pulses every 8 cycles.
- en dropped mid-scan at z=0100 → next cycle z=0, z_valid=0. Re-enabling restarts at z=0001 with no wrap pulse.
- Macro undefined: mode=1, dwell=5, i=1, i_valid=1 → z=0010 next cycle, wrap stays 0, and i_ready=1.
